// File: rtl/qam_frame_ctrl.sv
// Frame sequencer feeding the QAM mapper: preamble words, up to PAYLOAD_LEN
// pass-through source words, then an idle guard gap; single-shot or continuous.
module qam_frame_ctrl #(
    parameter int unsigned              DATA_WIDTH    = 8,
    parameter int unsigned              PREAMBLE_LEN  = 4,
    parameter logic [DATA_WIDTH-1:0]    PREAMBLE_WORD = DATA_WIDTH'(8'hA5),
    parameter int unsigned              PAYLOAD_LEN   = 16,
    parameter int unsigned              GAP_LEN       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    input  logic                  src_last,
    output logic                  src_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);

    // state      | meaning
    // S_IDLE     | waiting for start
    // S_PREAMBLE | emitting PREAMBLE_LEN fixed words, sof on the first
    // S_PAYLOAD  | zero-latency pass-through of source words until eof
    // S_GAP      | GAP_LEN idle cycles, then cont picks PREAMBLE or IDLE
    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_PAYLOAD,
        S_GAP
    } state_t;

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] PAY_LAST = 16'(PAYLOAD_LEN - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_LEN - 1);
    localparam bit          HAS_GAP  = (GAP_LEN != 0);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            gap_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        frame_cnt_d = frame_cnt_q;
        out_data    = '0;
        out_valid   = 1'b0;
        out_sof     = 1'b0;
        out_eof     = 1'b0;
        src_ready   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PREAMBLE;
                    cnt_d   = '0;
                end
            end
            S_PREAMBLE: begin
                out_data  = PREAMBLE_WORD;
                out_valid = 1'b1;
                out_sof   = (cnt_q == '0);
                if (out_ready) begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = S_PAYLOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_PAYLOAD: begin
                out_data  = src_data;
                out_valid = src_valid;
                src_ready = out_ready;
                out_eof   = src_valid & (src_last | (cnt_q == PAY_LAST));
                if (src_valid && out_ready) begin
                    if (out_eof) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        cnt_d       = '0;
                        if (HAS_GAP) begin
                            state_d = S_GAP;
                            gap_d   = GAP_LAST;
                        end else begin
                            state_d = cont ? S_PREAMBLE : S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = cont ? S_PREAMBLE : S_IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a same-cycle eof transfer.
        if (abort) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            gap_d       = '0;
            frame_cnt_d = frame_cnt_q;
            src_ready   = 1'b0;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_qam_frame_ctrl.sv
// Randomized bench for qam_frame_ctrl: a queue-based frame model predicts the
// output word stream, gap lengths and frame count from the source sequence.
module tb_qam_frame_ctrl;

    localparam int PRE = 4;
    localparam int PAY = 16;
    localparam int GAP = 8;
    localparam logic [7:0] PWORD = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] src_data = '0;
    logic       src_valid = 1'b0;
    logic       src_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       src_ready, out_valid, out_sof, out_eof, busy;
    logic [7:0] out_data;
    logic [15:0] frame_cnt;

    logic       src_ready2, out_valid2, out_sof2, out_eof2, busy2;
    logic [7:0] out_data2;
    logic [15:0] frame_cnt2;

    always #5 clk = ~clk;

    qam_frame_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
        .src_data(src_data), .src_valid(src_valid), .src_last(src_last),
        .src_ready(src_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    qam_frame_ctrl #(.GAP_LEN(0)) dut_nogap (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
        .src_data(src_data), .src_valid(src_valid), .src_last(src_last),
        .src_ready(src_ready2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(out_ready), .out_sof(out_sof2), .out_eof(out_eof2),
        .busy(busy2), .frame_cnt(frame_cnt2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] src_w[$];
    bit         src_l[$];
    int         src_idx;
    bit         hold;
    logic [9:0] cap[$];
    logic [9:0] exp_q[$];
    int         gaps[$];
    bit         after_eof;
    int         gap_run;
    int         eof_seen;
    int         cont_frames;
    bit         prev_stall;
    logic [9:0] prev_word;
    bit         prev_ab;

    task automatic clear_bench();
        cap.delete(); exp_q.delete(); gaps.delete();
        src_idx = 0; hold = 0; after_eof = 0; gap_run = 0; eof_seen = 0;
        prev_stall = 0; prev_ab = 0; cont_frames = 0;
    endtask

    task automatic reset_all();
        rst = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b0; out_ready = 1'b0; cont = 1'b0;
        clear_bench();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_seq(input int n);
        src_w.delete(); src_l.delete();
        for (int i = 0; i < n; i++) begin
            src_w.push_back(8'(i));
            src_l.push_back(1'b0);
        end
    endtask

    // Frame model: preamble words, then source words until last flag or PAY words.
    // nframes == 0 means keep framing until the source sequence is exhausted.
    task automatic build_exp(input int first, input int nframes, output int frames_out);
        int  idx = first;
        int  f = 0;
        bit  e;
        exp_q.delete();
        while ((nframes == 0) ? (idx < src_w.size()) : (f < nframes)) begin
            for (int p = 0; p < PRE; p++) exp_q.push_back({(p == 0), 1'b0, PWORD});
            for (int k = 0; idx < src_w.size(); k++) begin
                e = src_l[idx] || (k == PAY - 1);
                exp_q.push_back({1'b0, e, src_w[idx]});
                idx++;
                if (e) break;
            end
            f++;
        end
        frames_out = f;
    endtask

    task automatic step(input int pv, input int pr, input bit st, input bit ab);
        @(posedge clk); #1;
        start = st;
        abort = ab;
        if (!hold) begin
            if (src_idx < src_w.size() && int'($urandom_range(99)) < pv) begin
                src_valid = 1'b1; src_data = src_w[src_idx]; src_last = src_l[src_idx];
            end else begin
                src_valid = 1'b0; src_data = 8'($urandom); src_last = 1'($urandom);
            end
        end
        out_ready = (int'($urandom_range(99)) < pr);
        cont = (eof_seen < cont_frames);
        @(negedge clk);
        if (prev_stall) begin
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_word", 32'({out_sof, out_eof, out_data}), 32'(prev_word));
        end
        if (prev_ab) check_eq("abort_idle", 32'(busy), 32'd0);
        if (ab) check_eq("abort_src_ready", 32'(src_ready), 32'd0);
        if (after_eof) begin
            if (out_valid || !busy) begin
                gaps.push_back(gap_run);
                after_eof = 0;
            end else begin
                gap_run++;
            end
        end
        if (out_valid && out_ready && !ab) begin
            cap.push_back({out_sof, out_eof, out_data});
            if (out_eof) begin
                after_eof = 1; gap_run = 0; eof_seen++;
            end
        end
        if (src_valid && src_ready) begin
            src_idx++; hold = 0;
        end else begin
            hold = src_valid;
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_sof, out_eof, out_data};
        prev_ab    = ab;
    endtask

    task automatic run_frames(input int pv, input int pr, input int start_at, input int abort_at, input int max);
        int n = 0;
        step(pv, pr, 1'b1, 1'b0);
        do begin
            step(pv, pr, cap.size() == start_at, cap.size() == abort_at);
            n++;
        end while (busy && n < max);
        check_eq("timeout_busy", 32'(busy), 32'd0);
    endtask

    task automatic compare_stream();
        check_eq("n_words", 32'(cap.size()), 32'(exp_q.size()));
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            check_eq($sformatf("word%0d", i), 32'(cap[i]), 32'(exp_q[i]));
    endtask

    task automatic check_gaps(input int n);
        check_eq("n_gaps", 32'(gaps.size()), 32'(n));
        foreach (gaps[i]) check_eq("gap_len", 32'(gaps[i]), 32'(GAP));
    endtask

    initial begin
        int  f;
        int  n;
        bit  seen;

        // Reset values, with live-looking inputs applied.
        rst = 1'b1; src_valid = 1'b1; out_ready = 1'b1; src_data = 8'h3C; start = 1'b1;
        #12;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_src_ready", 32'(src_ready), 32'd0);
        check_eq("rst_sof_eof", 32'({out_sof, out_eof}), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        reset_all();
        step(100, 100, 1'b1, 1'b1);
        step(100, 100, 1'b0, 1'b0);
        check_eq("start_abort_idle", 32'(busy), 32'd0);

        // Basic frame; a start pulse mid-payload must be ignored.
        reset_all();
        load_seq(16);
        build_exp(0, 1, f);
        run_frames(100, 100, 10, -1, 200);
        compare_stream();
        check_gaps(1);
        check_eq("basic_frame_cnt", 32'(frame_cnt), 32'd1);
        check_eq("basic_consumed", 32'(src_idx), 32'd16);

        // Random backpressure, source gaps and early last flags.
        for (int r = 0; r < 3; r++) begin
            reset_all();
            src_w.delete(); src_l.delete();
            for (int i = 0; i < 60; i++) begin
                src_w.push_back(8'($urandom));
                src_l.push_back(($urandom_range(99) < 12) || (i == 59));
            end
            build_exp(0, 0, f);
            cont_frames = f;
            run_frames(70, 50, -1, -1, 3000);
            compare_stream();
            check_gaps(f);
            check_eq("rand_frame_cnt", 32'(frame_cnt), 32'(f));
            check_eq("rand_consumed", 32'(src_idx), 32'd60);
        end

        // Short frame: last on payload word 4, next word left untouched.
        reset_all();
        load_seq(32);
        src_l[4] = 1'b1;
        build_exp(0, 1, f);
        run_frames(100, 100, -1, -1, 200);
        compare_stream();
        check_gaps(1);
        repeat (3) step(100, 100, 1'b0, 1'b0);
        check_eq("short_consumed", 32'(src_idx), 32'd5);
        check_eq("short_frame_cnt", 32'(frame_cnt), 32'd1);

        // Continuous mode: three back-to-back frames.
        reset_all();
        load_seq(48);
        cont_frames = 3;
        build_exp(0, 3, f);
        run_frames(100, 100, -1, -1, 500);
        compare_stream();
        check_gaps(3);
        check_eq("cont_frame_cnt", 32'(frame_cnt), 32'd3);

        // Abort on payload word 7, then a fresh frame from the same source.
        reset_all();
        load_seq(32);
        run_frames(100, 100, -1, PRE + 7, 200);
        check_eq("abort_words_out", 32'(cap.size()), 32'(PRE + 7));
        check_eq("abort_consumed", 32'(src_idx), 32'd7);
        check_eq("abort_frame_cnt", 32'(frame_cnt), 32'd0);
        cap.delete(); gaps.delete(); after_eof = 0;
        build_exp(7, 1, f);
        run_frames(100, 100, -1, -1, 200);
        compare_stream();
        check_eq("after_abort_frame_cnt", 32'(frame_cnt), 32'd1);

        // Asynchronous reset in the middle of the preamble.
        reset_all();
        load_seq(16);
        step(100, 100, 1'b1, 1'b0);
        step(100, 100, 1'b0, 1'b0);
        step(100, 100, 1'b0, 1'b0);
        check_eq("pre_valid", 32'(out_valid), 32'd1);
        check_eq("pre_data", 32'(out_data), 32'(PWORD));
        #2 rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_out_data", 32'(out_data), 32'd0);
        check_eq("arst_src_ready", 32'(src_ready), 32'd0);

        // GAP_LEN=0 build: eof goes straight to the next preamble under cont.
        reset_all();
        load_seq(40);
        foreach (src_l[i]) src_l[i] = 1'b1;
        cont_frames = 1000;
        step(100, 100, 1'b1, 1'b0);
        n = 0; seen = 0;
        while (!seen && n < 60) begin
            step(100, 100, 1'b0, 1'b0);
            n++;
            seen = out_valid2 && out_ready && out_eof2;
        end
        check_eq("g0_eof_seen", 32'(seen), 32'd1);
        step(100, 100, 1'b0, 1'b0);
        check_eq("g0_valid", 32'(out_valid2), 32'd1);
        check_eq("g0_sof", 32'(out_sof2), 32'd1);
        check_eq("g0_data", 32'(out_data2), 32'(PWORD));
        check_eq("g0_busy", 32'(busy2), 32'd1);
        check_eq("g0_src_ready", 32'(src_ready2), 32'd0);
        check_eq("g0_frame_cnt", 32'(frame_cnt2), 32'd1);

        reset_all();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
